// File: rtl/dmem_pkg.sv
// Shared constants, response payload and request legality check for the
// byte-addressed data memory.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] FLT_OK       = 2'b00;
  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_ILLEGAL  = 2'b10;

  localparam int unsigned READ_LAT_MIN = 1;
  localparam int unsigned READ_LAT_MAX = 4;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
    logic [1:0]  fault;
    logic        is_store;
  } rsp_t;

  // Illegal funct3 outranks misalignment.
  function automatic logic [1:0] check_req(input logic we, input logic [2:0] funct3,
                                           input logic [1:0] offset);
    logic illegal;
    logic misalign;
    if (we) begin
      illegal = !((funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W));
    end else begin
      illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    end
    misalign = ((funct3[1:0] == 2'b01) && offset[0]) ||
               ((funct3[1:0] == 2'b10) && (offset != 2'b00));
    if (illegal) begin
      return FLT_ILLEGAL;
    end else if (misalign) begin
      return FLT_MISALIGN;
    end
    return FLT_OK;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Selects the addressed lane of a memory word and sign/zero-extends it
// according to the load funct3.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result_c
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b   = word[{offset, 3'b000} +: 8];
    // Odd halfword offsets fault upstream, so offset[1] alone picks the half.
    lane_h   = offset[1] ? word[31:16] : word[15:0];
    result_c = '0;
    case (funct3)
      F3_B:    result_c = {{24{lane_b[7]}}, lane_b};
      F3_H:    result_c = {{16{lane_h[15]}}, lane_h};
      F3_W:    result_c = word;
      F3_BU:   result_c = {24'h000000, lane_b};
      F3_HU:   result_c = {16'h0000, lane_h};
      default: result_c = '0;
    endcase
  end

endmodule

// File: rtl/dmem_bytelane.sv
// Byte-addressed RV32I data memory with byte-lane stores, extending loads,
// fault reporting and a fixed-latency in-order response pipeline.
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned READ_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_fault,
  output logic              rsp_is_store
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  if ((READ_LAT < READ_LAT_MIN) || (READ_LAT > READ_LAT_MAX)) begin : g_bad_read_lat
    $error("dmem_bytelane: READ_LAT must be within 1..4");
  end
  if ((DEPTH_WORDS < 4) || ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0)) begin : g_bad_depth
    $error("dmem_bytelane: DEPTH_WORDS must be a power of two >= 4");
  end

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic [1:0]       offset;
  logic [1:0]       fault;
  logic             store_en;
  logic [3:0]       byte_en;
  logic [31:0]      store_data;
  logic [31:0]      load_word;
  logic [31:0]      load_data;
  rsp_t             entry;
  rsp_t             pipe [READ_LAT];
  logic             unused_addr;

  // Upper address bits alias; fold them so they are visibly consumed.
  assign unused_addr = ^req_addr;
  assign idx         = req_addr[IDX_W+1:2];
  assign offset      = req_addr[1:0];
  assign load_word   = mem[idx];

  // Legality and store lane/data steering
  always_comb begin
    fault      = check_req(req_we, req_funct3, offset);
    store_en   = req_valid && req_we && (fault == FLT_OK) && !rst;
    byte_en    = '0;
    store_data = req_wdata;
    case (req_funct3)
      F3_B: begin
        byte_en    = 4'b0001 << offset;
        store_data = {4{req_wdata[7:0]}};
      end
      F3_H: begin
        byte_en    = offset[1] ? 4'b1100 : 4'b0011;
        store_data = {2{req_wdata[15:0]}};
      end
      F3_W:    byte_en = 4'b1111;
      default: byte_en = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[idx][8*b +: 8] <= store_data[8*b +: 8];
        end
      end
    end
  end

  dmem_load_align u_load_align (
    .word     (load_word),
    .offset   (offset),
    .funct3   (req_funct3),
    .result_c (load_data)
  );

  // Response entering the pipeline; idle cycles carry an all-zero payload.
  always_comb begin
    entry = '0;
    if (req_valid) begin
      entry.valid    = 1'b1;
      entry.fault    = fault;
      entry.is_store = req_we;
      if (!req_we && (fault == FLT_OK)) begin
        entry.rdata = load_data;
      end
    end
  end

  for (genvar g = 0; g < READ_LAT; g++) begin : g_stage
    rsp_t src;
    if (g == 0) begin : g_head
      assign src = entry;
    end else begin : g_tail
      assign src = pipe[g-1];
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        pipe[g] <= '0;
      end else begin
        pipe[g] <= src;
      end
    end
  end

  assign rsp_valid    = pipe[READ_LAT-1].valid;
  assign rsp_rdata    = pipe[READ_LAT-1].rdata;
  assign rsp_fault    = pipe[READ_LAT-1].fault;
  assign rsp_is_store = pipe[READ_LAT-1].is_store;

endmodule

// File: tb/tb_dmem_bytelane.sv
// Directed vector bench for dmem_bytelane; two instances (READ_LAT 3 and 2)
// share the stimulus and each is checked cycle-exactly against its latency.
module tb_dmem_bytelane;
  import dmem_pkg::*;

  localparam int unsigned LAT_A = 3;
  localparam int unsigned LAT_B = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;

  logic        a_valid, b_valid;
  logic [31:0] a_rdata, b_rdata;
  logic [1:0]  a_fault, b_fault;
  logic        a_is_store, b_is_store;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  fault;
    int          gap;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic [1:0]  fault;
    logic        is_store;
  } exp_t;

  vec_t vecs[$];
  exp_t q_a[$];
  exp_t q_b[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   chk_on = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_bytelane #(.DEPTH_WORDS(1024), .ADDR_W(32), .READ_LAT(LAT_A)) u_dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(a_valid), .rsp_rdata(a_rdata), .rsp_fault(a_fault),
    .rsp_is_store(a_is_store)
  );

  dmem_bytelane #(.DEPTH_WORDS(1024), .ADDR_W(32), .READ_LAT(LAT_B)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(b_valid), .rsp_rdata(b_rdata), .rsp_fault(b_fault),
    .rsp_is_store(b_is_store)
  );

  task automatic compare(input string name, input logic v, input logic [31:0] d,
                         input logic [1:0] f, input logic s, input logic ev,
                         input logic [31:0] ed, input logic [1:0] ef, input logic es);
    n_vec++;
    if (v !== ev || d !== ed || f !== ef || s !== es) begin
      n_err++;
      $display("FAIL %s cyc=%0d got valid=%b rdata=%h fault=%b store=%b, want valid=%b rdata=%h fault=%b store=%b",
               name, cyc, v, d, f, s, ev, ed, ef, es);
    end
  endtask

  // Each cycle: either the expected response is due, or the outputs must be idle zeros.
  always @(negedge clk) begin
    exp_t e;
    if (chk_on) begin
      if (q_a.size() > 0 && q_a[0].due == cyc) begin
        e = q_a.pop_front();
        compare("lat3_rsp", a_valid, a_rdata, a_fault, a_is_store, 1'b1, e.rdata, e.fault, e.is_store);
      end else begin
        compare("lat3_idle", a_valid, a_rdata, a_fault, a_is_store, 1'b0, 32'h0, 2'b00, 1'b0);
      end
      if (q_b.size() > 0 && q_b[0].due == cyc) begin
        e = q_b.pop_front();
        compare("lat2_rsp", b_valid, b_rdata, b_fault, b_is_store, 1'b1, e.rdata, e.fault, e.is_store);
      end else begin
        compare("lat2_idle", b_valid, b_rdata, b_fault, b_is_store, 1'b0, 32'h0, 2'b00, 1'b0);
      end
    end
  end

  task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rdata,
                     input logic [1:0] fault, input int gap);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.fault = fault; v.gap = gap;
    vecs.push_back(v);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
  endtask

  task automatic issue(input vec_t v);
    exp_t e;
    repeat (v.gap) next_cycle();
    drive(v.we, v.f3, v.addr, v.wdata);
    e.rdata = v.rdata; e.fault = v.fault; e.is_store = v.we;
    e.due = cyc + int'(LAT_A);
    q_a.push_back(e);
    e.due = cyc + int'(LAT_B);
    q_b.push_back(e);
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    // byte lanes
    add(1, F3_W,  32'h100, 32'h00000000, 32'h0,        FLT_OK, 0);
    add(1, F3_B,  32'h101, 32'h12345680, 32'h0,        FLT_OK, 0);
    add(0, F3_W,  32'h100, 32'h0,        32'h00008000, FLT_OK, 0);
    add(0, F3_B,  32'h101, 32'h0,        32'hFFFFFF80, FLT_OK, 0);
    add(0, F3_BU, 32'h101, 32'h0,        32'h00000080, FLT_OK, 0);
    // halfword lanes
    add(1, F3_W,  32'h200, 32'h11223344, 32'h0,        FLT_OK, 2);
    add(1, F3_H,  32'h202, 32'hAAAABEEF, 32'h0,        FLT_OK, 0);
    add(0, F3_W,  32'h200, 32'h0,        32'hBEEF3344, FLT_OK, 0);
    add(0, F3_H,  32'h202, 32'h0,        32'hFFFFBEEF, FLT_OK, 0);
    add(0, F3_HU, 32'h202, 32'h0,        32'h0000BEEF, FLT_OK, 1);
    // faults, none of which may disturb 0x300
    add(1, F3_W,  32'h300, 32'hA5A5A5A5, 32'h0,        FLT_OK, 0);
    add(1, F3_W,  32'h301, 32'hDEADBEEF, 32'h0,        FLT_MISALIGN, 0);
    add(0, F3_W,  32'h300, 32'h0,        32'hA5A5A5A5, FLT_OK, 0);
    add(0, F3_H,  32'h303, 32'h0,        32'h0,        FLT_MISALIGN, 0);
    add(0, 3'b111, 32'h300, 32'h0,       32'h0,        FLT_ILLEGAL, 0);
    add(0, 3'b110, 32'h300, 32'h0,       32'h0,        FLT_ILLEGAL, 0);
    add(0, 3'b011, 32'h300, 32'h0,       32'h0,        FLT_ILLEGAL, 0);
    add(1, F3_BU, 32'h300, 32'h0,        32'h0,        FLT_ILLEGAL, 0);
    add(1, F3_HU, 32'h301, 32'h0,        32'h0,        FLT_ILLEGAL, 0);
    add(1, 3'b110, 32'h302, 32'h0,       32'h0,        FLT_ILLEGAL, 0);
    add(1, F3_H,  32'h301, 32'h1111,     32'h0,        FLT_MISALIGN, 0);
    add(0, F3_W,  32'h300, 32'h0,        32'hA5A5A5A5, FLT_OK, 0);
    add(0, F3_HU, 32'h301, 32'h0,        32'h0,        FLT_MISALIGN, 0);
    // back-to-back store then loads
    add(1, F3_W,  32'h040, 32'hCAFEF00D, 32'h0,        FLT_OK, 3);
    add(0, F3_W,  32'h040, 32'h0,        32'hCAFEF00D, FLT_OK, 0);
    add(0, F3_B,  32'h043, 32'h0,        32'hFFFFFFCA, FLT_OK, 0);
    // aliasing onto word 0
    add(1, F3_W,  32'h1000, 32'h12345678, 32'h0,        FLT_OK, 1);
    add(0, F3_W,  32'h0,   32'h0,        32'h12345678, FLT_OK, 0);
    add(0, F3_BU, 32'h2,   32'h0,        32'h00000034, FLT_OK, 0);
    add(0, F3_B,  32'h0,   32'h0,        32'h00000078, FLT_OK, 0);
    add(0, F3_H,  32'h0,   32'h0,        32'h00005678, FLT_OK, 0);
    add(1, F3_B,  32'h3,   32'h000000FF, 32'h0,        FLT_OK, 0);
    add(0, F3_W,  32'hFFFFF000, 32'h0,   32'hFF345678, FLT_OK, 0);
    add(1, F3_H,  32'h0,   32'h00007777, 32'h0,        FLT_OK, 0);
    add(1, F3_W,  32'h2,   32'h0,        32'h0,        FLT_MISALIGN, 0);
    add(0, F3_W,  32'h0,   32'h0,        32'hFF347777, FLT_OK, 0);
    add(0, F3_HU, 32'h2,   32'h0,        32'h0000FF34, FLT_OK, 0);
    add(0, F3_H,  32'h2,   32'h0,        32'hFFFFFF34, FLT_OK, 0);
    add(0, F3_B,  32'h3,   32'h0,        32'hFFFFFFFF, FLT_OK, 0);
    add(0, F3_B,  32'h1,   32'h0,        32'h00000077, FLT_OK, 0);

    rst = 1'b1;
    repeat (2) next_cycle();
    chk_on = 1'b1;
    next_cycle();
    rst = 1'b0;

    foreach (vecs[i]) issue(vecs[i]);
    repeat (6) next_cycle();

    // Reset mid-flight: load, then reset with a load, then a store under reset.
    drive(1'b0, F3_W, 32'h040, 32'h0);
    next_cycle();
    rst = 1'b1;
    drive(1'b0, F3_W, 32'h200, 32'h0);
    next_cycle();
    drive(1'b1, F3_W, 32'h040, 32'hFFFFFFFF);
    next_cycle();
    rst = 1'b0;
    begin
      vec_t v;
      v.we = 1'b0; v.f3 = F3_W; v.addr = 32'h040; v.wdata = 32'h0;
      v.rdata = 32'hCAFEF00D; v.fault = FLT_OK; v.gap = 0;
      issue(v);
    end
    repeat (6) next_cycle();

    n_vec++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_err++;
      $display("FAIL drain pending lat3=%0d lat2=%0d, want 0 0", q_a.size(), q_b.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
